// File: rtl/mul_display_pkg.sv
// Shared glyph codes, scan states and segment patterns for the multiplier display.
package mul_display_pkg;

  localparam logic [3:0] GLYPH_DASH  = 4'hA;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;
  localparam int         NUM_DIGITS  = 4;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  // Active-high {g,f,e,d,c,b,a}; index 0 is the rightmost concatenation entry.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/mul_display_seg7_decode.sv
// Glyph code to active-high seven-segment pattern; codes B..E render blank.
module seg7_decode
  import mul_display_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (glyph)
      4'h0: seg = SEG_DIGITS[0];
      4'h1: seg = SEG_DIGITS[1];
      4'h2: seg = SEG_DIGITS[2];
      4'h3: seg = SEG_DIGITS[3];
      4'h4: seg = SEG_DIGITS[4];
      4'h5: seg = SEG_DIGITS[5];
      4'h6: seg = SEG_DIGITS[6];
      4'h7: seg = SEG_DIGITS[7];
      4'h8: seg = SEG_DIGITS[8];
      4'h9: seg = SEG_DIGITS[9];
      GLYPH_DASH: seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mul_display.sv
// Captures a sign-magnitude product, converts it to decimal glyphs and scans
// a 4-digit multiplexed seven-segment display with a blank gap between digits.
module mul_display
  import mul_display_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] product,
  input  logic       zero_flag,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       shown_valid
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);

  logic [4:0]       held_product;
  logic             held_zero;

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;

  logic [4:0]       cur_product;
  logic             cur_zero;
  logic             cur_valid;
  logic [3:0]       mag;
  logic             tens;
  logic [3:0]       units;
  logic             neg;
  logic [3:0]       glyph;
  logic [6:0]       seg_decoded;
  logic [6:0]       seg_on;
  logic [3:0]       an_on;

  // The outputs are registered from next-cycle values, so conversion looks
  // through a same-edge load; the new glyph appears right after the capture.
  assign cur_product = load ? product : held_product;
  assign cur_zero    = load ? zero_flag : held_zero;
  assign cur_valid   = load | shown_valid;

  always_comb begin
    mag   = cur_zero ? 4'd0 : cur_product[3:0];
    tens  = (mag >= 4'd10);
    units = tens ? (mag - 4'd10) : mag;
    neg   = cur_product[4] & ~cur_zero & (mag != 4'd0);
  end

  always_comb begin
    glyph = GLYPH_BLANK;
    if (cur_valid) begin
      case (idx_next)
        2'd0: glyph = units;
        2'd1: glyph = tens ? 4'd1 : GLYPH_BLANK;
        2'd2: glyph = neg ? GLYPH_DASH : GLYPH_BLANK;
        default: glyph = GLYPH_BLANK;
      endcase
    end else begin
      glyph = (idx_next == 2'd3) ? GLYPH_BLANK : GLYPH_DASH;
    end
  end

  seg7_decode u_decode (
    .glyph (glyph),
    .seg   (seg_decoded)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
          state_next = BLANK;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = BLANK;
      end
    endcase
  end

  always_comb begin
    seg_on = SEG_OFF;
    an_on  = 4'h0;
    if (state_next == DRIVE) begin
      seg_on = seg_decoded;
      an_on  = 4'(1) << idx_next;
    end
  end

  // Held operand registers carry no reset; shown_valid masks them until a load.
  always_ff @(posedge clk) begin
    if (load) begin
      held_product <= product;
      held_zero    <= zero_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      shown_valid <= 1'b0;
      seg         <= ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
      an          <= ACTIVE_LOW_AN ? 4'hF : 4'h0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      shown_valid <= cur_valid;
      seg         <= ACTIVE_LOW_SEG ? ~seg_on : seg_on;
      an          <= ACTIVE_LOW_AN ? ~an_on : an_on;
    end
  end

endmodule

// File: tb/tb_mul_display.sv
// Bench for mul_display: directed scenarios plus random loads/resets against
// a slot-arithmetic reference of what the display should show each cycle.
module tb_mul_display;

  localparam int S = 4;
  localparam int B = 2;
  localparam int P = S + B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [4:0] product = 5'd0;
  logic       zero_flag = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       shown_valid;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: edges since reset and the last captured value.
  int  k = 0;
  bit  m_valid = 0;
  int  m_value = 0;
  bit  m_neg = 0;

  mul_display #(
    .SCAN_DIV       (S),
    .BLANK_CYCLES   (B),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .product     (product),
    .zero_flag   (zero_flag),
    .seg         (seg),
    .an          (an),
    .shown_valid (shown_valid)
  );

  always #5 clk = ~clk;

  // -1 = blank, -2 = dash, otherwise a decimal digit; returns active-low pins.
  function automatic logic [6:0] pins_for(input int code);
    logic [6:0] hi;
    case (code)
      0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
      4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
      8: hi = 7'h7F;  9: hi = 7'h6F;  -2: hi = 7'h40;
      default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  function automatic int digit_code(input int pos);
    if (!m_valid) return (pos == 3) ? -1 : -2;
    case (pos)
      0: return m_value % 10;
      1: return (m_value >= 10) ? m_value / 10 : -1;
      2: return m_neg ? -2 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Clock one edge with the current inputs, advance the reference, compare.
  task automatic step();
    int phase, slot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    @(posedge clk);
    if (rst) begin
      k = 0;
      m_valid = 0;
    end else begin
      k++;
      if (load) begin
        m_valid = 1;
        m_value = zero_flag ? 0 : int'(product[3:0]);
        m_neg   = product[4] && (m_value != 0);
      end
    end
    #1;
    phase = k % P;
    slot  = (k / P) % 4;
    if (!rst && phase >= B) begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = pins_for(digit_code(slot));
    end else begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end
    check("an", {4'h0, an}, {4'h0, exp_an});
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("shown_valid", {7'h0, shown_valid}, {7'h0, m_valid});
    check("one_anode", {7'h0, ($countones(~an) <= 1)}, 8'h01);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [4:0] p, input logic z);
    product = p;
    zero_flag = z;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset, then free-run showing dashes.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(4 * P + 3);

    do_load(5'b01001, 1'b0);
    run(4 * P);
    check("digit0_nine", {1'b0, pins_for(digit_code(0))}, 8'h10);
    do_load(5'b10110, 1'b0);
    run(4 * P);
    check("digit2_dash", {1'b0, pins_for(digit_code(2))}, 8'h3F);
    do_load(5'b10000, 1'b1);
    run(4 * P);
    check("neg_zero_nodash", {1'b0, pins_for(digit_code(2))}, 8'h7F);
    do_load(5'b01111, 1'b0);
    run(4 * P);
    check("digit1_one", {1'b0, pins_for(digit_code(1))}, 8'h79);

    // Load mid-DRIVE of digit 0, then reset mid-slot.
    guard = 0;
    while (!((k / P) % 4 == 0 && (k % P) == B + 1) && guard < 10 * P) begin
      step();
      guard++;
    end
    check("reach_drive0", {7'h0, (guard < 10 * P)}, 8'h01);
    do_load(5'b00111, 1'b0);
    product = 5'b10011;
    do_load(5'b10011, 1'b0);
    run(P + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2 * P);

    // Random loads with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 7) == 0);
      product   = 5'($urandom);
      zero_flag = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    run(4 * P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
